// File: rtl/servo_ramp_ctrl.sv
// Multi-channel servo position scheduler: once per frame, slews each channel's pulse length toward its target.
// Optional build macro SERVO_RAMP_CLAMP_EN clamps accepted targets to [MIN_US, MAX_US].
module servo_ramp_ctrl #(
  parameter int CLK_F     = 50,
  parameter int FRAME_US  = 20000,
  parameter int NUM_CH    = 4,
  parameter int CENTER_US = 1500,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_ch,
  input  logic [15:0]           cmd_target,
  input  logic [7:0]            cmd_step,
  output logic [NUM_CH*16-1:0]  pulse_len,
  output logic [NUM_CH-1:0]     busy,
  output logic                  frame_tick,
  output logic                  dbg_state
);

  localparam int PW = (CLK_F > 1) ? $clog2(CLK_F) : 1;
  localparam int UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int IW = $clog2(NUM_CH);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_F - 1);
  localparam logic [UW-1:0] US_LAST  = UW'(FRAME_US - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);
  localparam logic [15:0]   CENTER   = 16'(CENTER_US);

  if (MIN_US > MAX_US) begin : g_bad_limits
    $error("servo_ramp_ctrl: MIN_US must not exceed MAX_US");
  end

  typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [PW-1:0]   prescaler;
  logic [UW-1:0]   us_cnt;
  logic [15:0]     cur  [NUM_CH];
  logic [15:0]     tgt  [NUM_CH];
  logic [7:0]      step [NUM_CH];

  logic            pre_wrap;
  logic            cmd_accept;
  logic [15:0]     tgt_in;
  logic [15:0]     sel_cur;
  logic [15:0]     sel_tgt;
  logic [7:0]      sel_step;
  logic [16:0]     diff;
  logic [15:0]     slew_next;

  // Handshake: a command transfers on any rising CLK where cmd_valid && cmd_ready;
  // the source must hold cmd_valid and the payload stable until that edge.
  assign cmd_accept = cmd_valid && cmd_ready;
  assign pre_wrap   = (prescaler == PRE_LAST);
  assign frame_tick = pre_wrap && (us_cnt == US_LAST);
  assign dbg_state  = (state == UPDATE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      prescaler <= '0;
      us_cnt    <= '0;
    end else if (pre_wrap) begin
      prescaler <= '0;
      us_cnt    <= (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_comb begin
    tgt_in = cmd_target;
`ifdef SERVO_RAMP_CLAMP_EN
    if (cmd_target < 16'(MIN_US))      tgt_in = 16'(MIN_US);
    else if (cmd_target > 16'(MAX_US)) tgt_in = 16'(MAX_US);
`endif
  end

  // Slew datapath for the channel currently addressed by idx.
  always_comb begin
    sel_cur  = cur[0];
    sel_tgt  = tgt[0];
    sel_step = step[0];
    for (int n = 1; n < NUM_CH; n++) begin
      if (idx == IW'(n)) begin
        sel_cur  = cur[n];
        sel_tgt  = tgt[n];
        sel_step = step[n];
      end
    end
    if (sel_cur > sel_tgt) diff = {1'b0, sel_cur} - {1'b0, sel_tgt};
    else                   diff = {1'b0, sel_tgt} - {1'b0, sel_cur};
    if (sel_step == 8'd0 || diff <= {9'd0, sel_step}) slew_next = sel_tgt;
    else if (sel_cur < sel_tgt)                       slew_next = sel_cur + {8'd0, sel_step};
    else                                              slew_next = sel_cur - {8'd0, sel_step};
  end

  // Command writes happen in the same edge as the IDLE->UPDATE transition, so
  // a command colliding with frame_tick is already in tgt when UPDATE reads it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      idx       <= '0;
      cmd_ready <= 1'b1;
      for (int n = 0; n < NUM_CH; n++) begin
        cur[n]  <= CENTER;
        tgt[n]  <= CENTER;
        step[n] <= 8'd0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (cmd_accept && cmd_ch == 3'(n)) begin
          tgt[n]  <= tgt_in;
          step[n] <= cmd_step;
        end
      end
      case (state)
        IDLE: begin
          if (frame_tick) begin
            state     <= UPDATE;
            idx       <= '0;
            cmd_ready <= 1'b0;
          end
        end
        UPDATE: begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (idx == IW'(n)) cur[n] <= slew_next;
          end
          if (idx == IDX_LAST) begin
            state     <= IDLE;
            idx       <= '0;
            cmd_ready <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign pulse_len[16*g +: 16] = cur[g];
    assign busy[g]               = (cur[g] != tgt[g]);
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Bench for servo_ramp_ctrl with CLK_F=2, FRAME_US=100 (200-cycle frames), NUM_CH=4.
// Per-frame expectations go into exp_q; the monitor compares them when cmd_ready re-asserts.
module tb_servo_ramp_ctrl;

  localparam int NUM_CH = 4;
  localparam int W      = NUM_CH * 16 + NUM_CH;

`ifdef SERVO_RAMP_CLAMP_EN
  localparam logic [15:0] CLAMP_EXP = 16'd2000;
`else
  localparam logic [15:0] CLAMP_EXP = 16'd2500;
`endif

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_ch;
  logic [15:0]          cmd_target;
  logic [7:0]           cmd_step;
  logic [NUM_CH*16-1:0] pulse_len;
  logic [NUM_CH-1:0]    busy;
  logic                 frame_tick;
  logic                 dbg_state;

  logic [W-1:0] exp_q[$];
  int           errors = 0;
  int           checks = 0;
  logic         prev_ready;

  servo_ramp_ctrl #(
    .CLK_F(2), .FRAME_US(100), .NUM_CH(NUM_CH),
    .CENTER_US(1500), .MIN_US(1000), .MAX_US(2000)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_step(cmd_step),
    .pulse_len(pulse_len), .busy(busy), .frame_tick(frame_tick),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] frame_vec(input logic [15:0] c0, c1, c2, c3,
                                             input logic [3:0] b);
    return {b, c3, c2, c1, c0};
  endfunction

  task automatic push_exp(input logic [15:0] c0, c1, c2, c3, input logic [3:0] b);
    exp_q.push_back(frame_vec(c0, c1, c2, c3, b));
  endtask

  // monitor: an UPDATE burst (or a reset) ends when cmd_ready rises
  always @(negedge CLK) begin
    if (prev_ready === 1'b0 && cmd_ready === 1'b1 && exp_q.size() > 0)
      check("frame", {busy, pulse_len}, exp_q.pop_front());
    prev_ready = cmd_ready;
  end

  // driver tasks; all are entered and left at a falling edge
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (frame_tick !== 1'b1 && n < 1000);
    if (frame_tick !== 1'b1) check("tick_timeout", W'(n), W'(200));
  endtask

  task automatic wait_frames(input int k);
    int n;
    for (int i = 0; i < k; i++) begin
      wait_tick(n);
      repeat (6) @(negedge CLK);
    end
  endtask

  task automatic send_cmd(input logic [2:0] ch, input logic [15:0] t, input logic [7:0] s,
                          output int w);
    w = 0;
    cmd_valid = 1'b1; cmd_ch = ch; cmd_target = t; cmd_step = s;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    if (cmd_ready !== 1'b1) check("cmd_timeout", W'(w), W'(0));
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n, w;
    RST_N = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_target = '0; cmd_step = '0;

    // reset: 5 cycles low, release on a falling edge
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    check("rst_pulse", W'(pulse_len), W'({4{16'd1500}}));
    check("rst_busy", W'(busy), W'(0));
    check("rst_ready", W'(cmd_ready), W'(1));
    check("rst_tick", W'(frame_tick), W'(0));
    check("rst_state", W'(dbg_state), W'(0));
    wait_tick(n);
    check("first_tick_cycles", W'(n + 1), W'(200));
    wait_tick(n);
    check("frame_period", W'(n), W'(200));
    repeat (10) @(negedge CLK);

    // ramp up ch1 by 30 per frame
    send_cmd(3'd1, 16'd1600, 8'd30, w);
    check("ramp_busy", W'(busy), W'(4'b0010));
    check("ramp_no_jump", W'(pulse_len), W'({4{16'd1500}}));
    push_exp(1500, 1530, 1500, 1500, 4'b0010);
    push_exp(1500, 1560, 1500, 1500, 4'b0010);
    push_exp(1500, 1590, 1500, 1500, 4'b0010);
    push_exp(1500, 1600, 1500, 1500, 4'b0000);
    wait_tick(n);
    repeat (2) @(negedge CLK);
    check("ch1_at_t2", W'(pulse_len[31:16]), W'(16'd1500));
    @(negedge CLK);
    check("ch1_at_t3", W'(pulse_len[31:16]), W'(16'd1530));
    repeat (3) @(negedge CLK);
    wait_frames(3);

    // jump, exact landing, then ramp down
    send_cmd(3'd2, 16'd1200, 8'd0, w);
    push_exp(1500, 1600, 1200, 1500, 4'b0000);
    wait_frames(1);
    send_cmd(3'd2, 16'd1150, 8'd100, w);
    push_exp(1500, 1600, 1150, 1500, 4'b0000);
    wait_frames(1);
    send_cmd(3'd2, 16'd1000, 8'd100, w);
    push_exp(1500, 1600, 1050, 1500, 4'b0100);
    push_exp(1500, 1600, 1000, 1500, 4'b0000);
    wait_frames(2);

    // back-to-back commands to ch0: last one wins
    send_cmd(3'd0, 16'd1800, 8'd5, w);
    send_cmd(3'd0, 16'd1400, 8'd0, w);
    check("b2b_busy", W'(busy), W'(4'b0001));
    push_exp(1400, 1600, 1000, 1500, 4'b0000);
    wait_frames(1);

    // collision: command presented in the frame_tick cycle
    push_exp(1400, 1600, 1000, 1700, 4'b0000);
    wait_tick(n);
    cmd_valid = 1'b1; cmd_ch = 3'd3; cmd_target = 16'd1700; cmd_step = 8'd200;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      cmd_valid = 1'b0;
      check("coll_ready_low", W'(cmd_ready), W'(0));
      if (i == 1) check("coll_state_upd", W'(dbg_state), W'(1));
      if (i == 4) check("coll_ch3_t4", W'(pulse_len[63:48]), W'(16'd1500));
    end
    @(negedge CLK);
    check("coll_ready_back", W'(cmd_ready), W'(1));
    check("coll_ch3_t5", W'(pulse_len[63:48]), W'(16'd1700));
    repeat (5) @(negedge CLK);

    // stall: command arrives one cycle into UPDATE
    wait_tick(n);
    @(negedge CLK);
    send_cmd(3'd1, 16'd1620, 8'd0, w);
    check("stall_cycles", W'(w), W'(4));
    push_exp(1400, 1620, 1000, 1700, 4'b0000);
    wait_frames(1);

    // clamp target and out-of-range channel
    send_cmd(3'd0, 16'd2500, 8'd0, w);
    send_cmd(3'd5, 16'd1234, 8'd0, w);
    check("clamp_busy", W'(busy), W'(4'b0001));
    push_exp(CLAMP_EXP, 1620, 1000, 1700, 4'b0000);
    wait_frames(1);

    // reset in the middle of UPDATE
    push_exp(1500, 1500, 1500, 1500, 4'b0000);
    wait_tick(n);
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("mid_rst_state", W'(dbg_state), W'(0));
    check("mid_rst_ready", W'(cmd_ready), W'(1));
    check("mid_rst_pulse", W'(pulse_len), W'({4{16'd1500}}));
    check("mid_rst_busy", W'(busy), W'(0));
    wait_tick(n);
    check("mid_rst_tick_cycles", W'(n + 1), W'(200));
    repeat (10) @(negedge CLK);

    // final report
    check("exp_q_drained", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_ramp_ctrl.md
# servo_ramp_ctrl

Multi-channel servo position scheduler that sits upstream of the per-channel servo PWM generators and drives their `pulse_len` inputs. It accepts position commands over a valid/ready handshake and keeps a 20 ms frame timebase. Once per frame it slews each channel's current pulse length toward its commanded target by a per-channel step, so servos never see step changes larger than commanded.

## Interface
- `CLK_F`, 50: CLK frequency in MHz; prescaler divides CLK down to 1 µs.
- `FRAME_US`, 20000: frame length in µs; matches the PWM period.
- `NUM_CH`, 4: number of servo channels, 2..8.
- `CENTER_US`, 1500: reset and default pulse length in µs.
- `MIN_US`, 1000: lower clamp limit, used only with the clamp macro.
- `MAX_US`, 2000: upper clamp limit, used only with the clamp macro.

Ports:
- `CLK` in 1: system clock.
- `RST_N` in 1: reset. One clock; reset is synchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command this cycle.
- `cmd_ch` in 3: target channel; values ≥ NUM_CH are accepted and discarded.
- `cmd_target` in 16: target pulse length in µs.
- `cmd_step` in 8: max change per frame in µs; 0 means jump on the next frame.
- `pulse_len` out NUM_CH*16: current pulse length per channel; channel n is bits [16n+15:16n].
- `busy` out NUM_CH: channel n current ≠ target.
- `frame_tick` out 1: one-cycle pulse at the end of each frame.

## Operation
- **Timebase**
  - `prescaler` counts 0..CLK_F-1.
  - `us_cnt` increments when the prescaler wraps and counts 0..FRAME_US-1.
  - `frame_tick`=1 for exactly the cycle where prescaler==CLK_F-1 and us_cnt==FRAME_US-1.
- **Per-channel registers**: `cur[n]` (16b), `tgt[n]` (16b), `step[n]` (8b).
- **FSM states**: IDLE, UPDATE.
  - IDLE: `cmd_ready`=1. On `frame_tick`, go to UPDATE with `idx`=0.
  - UPDATE: `cmd_ready`=0. Process channel `idx` each cycle. After idx==NUM_CH-1, return to IDLE. Length is exactly NUM_CH cycles.
- **Command accept** (`cmd_valid && cmd_ready`): write `tgt[cmd_ch]` and `step[cmd_ch]`. `cur` is never written by a command.
- **Slew rule for channel idx**, using a 17-bit difference d = |tgt − cur|:
  - If step==0 or d ≤ step: cur ← tgt.
  - Else if cur < tgt: cur ← cur + step.
  - Else: cur ← cur − step.
- **Outputs**
  - `busy[n]` is combinational from cur[n] != tgt[n].
  - `pulse_len` is driven directly from `cur`.
- **Reset values** (RST_N low at a rising edge):
  - cur = tgt = CENTER_US; step = 0.
  - prescaler = us_cnt = 0; FSM = IDLE; idx = 0.
  - `cmd_ready`=1, `frame_tick`=0, `busy`=0.
  - Resetting mid-UPDATE abandons the remaining channels.

## Timing
- A command accepted in cycle t is visible in `tgt` at t+1. It affects `cur` at the next UPDATE visit to that channel.
- A frame_tick in cycle t updates channel n's `cur`, visible at cycle t+2+n.
- If `frame_tick` and a command are accepted in the same cycle, the command is written first. The UPDATE that follows uses the new target.
- A command arriving during UPDATE stalls: `cmd_ready`=0 and `cmd_valid` must be held. Stall is at most NUM_CH cycles per frame.
- Back-to-back commands to the same channel in consecutive IDLE cycles: the last one wins.
- UPDATE always finishes long before the next tick, since NUM_CH ≪ CLK_F·FRAME_US.

## Configuration
- `SERVO_RAMP_CLAMP_EN` defined: on accept, `cmd_target` is clamped to [MIN_US, MAX_US] before being stored in `tgt`.
- Not defined: `cmd_target` is stored unmodified, and MIN_US/MAX_US are unused.

## Test plan
Bench runs with CLK_F=2, FRAME_US=100, NUM_CH=4.
- **Reset**: hold RST_N=0 for 5 cycles, release → all pulse_len=1500, busy=0, cmd_ready=1, first frame_tick exactly 200 cycles after release.
- **Ramp up**: cmd ch1 target=1600, step=30 → busy[1]=1. ch1 goes 1530, 1560, 1590, 1600 on successive frames. busy[1]=0 after the 4th update. Other channels stay at 1500.
- **Jump and ramp down**: cmd ch2 target=1200, step=0 → ch2=1200 after the first frame. Then target=1150, step=100 → 1150 after one frame (no undershoot).
- **Collision**: assert cmd_valid for ch3 target=1700, step=200 in the same cycle as frame_tick → accepted that cycle. cmd_ready=0 for the next 4 cycles. ch3=1700 at tick+5.
- **Clamp**: with SERVO_RAMP_CLAMP_EN, cmd ch0 target=2500, step=0 → ch0=2000. Without the macro → ch0=2500. Also cmd_ch=5 → no channel changes.
- **Mid-update reset**: drive RST_N=0 at tick+2 → all channels back at 1500, FSM in IDLE, us_cnt restarts at 0.
